// File: rtl/mux_scan_pkg.sv
// Shared constants and state encoding for the mux scan sequencer.
package mux_scan_pkg;

    localparam int NCH   = 4;
    localparam int SEL_W = 2;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        OUT  = 2'd2
    } state_e;

endpackage

// File: rtl/mux_next_ch.sv
// Finds the lowest enabled channel strictly above cur_i. With from_lo_i set,
// cur_i is ignored and treated as -1, so this returns the first enabled channel.
module mux_next_ch
    import mux_scan_pkg::*;
(
    input  logic [NCH-1:0]   mask_i,
    input  logic [SEL_W-1:0] cur_i,
    input  logic             from_lo_i,
    output logic [SEL_W-1:0] nxt_o,
    output logic             found_o
);

    // Descending scan so the last hit written is the lowest qualifying channel.
    always_comb begin
        nxt_o   = '0;
        found_o = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (mask_i[i] && (from_lo_i || (i > int'(cur_i)))) begin
                nxt_o   = SEL_W'(i);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Sequencer for a 4:1 bit mux: walks enabled channels, waits SETTLE extra
// cycles per channel, samples mux_y_i, and hands out a 4-bit snapshot over
// valid/ready, either once or back-to-back in continuous mode.
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int SETTLE = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             cont_i,
    input  logic [NCH-1:0]   ch_mask_i,
    output logic [SEL_W-1:0] sel_o,
    input  logic             mux_y_i,
    output logic [NCH-1:0]   scan_data_o,
    output logic             scan_valid_o,
    input  logic             scan_ready_i,
    output logic             busy_o,
    output logic             overrun_o
);

    localparam logic [CNT_W-1:0] SETTLE_CNT = CNT_W'(SETTLE);

    state_e            state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [NCH-1:0]    mask_q, mask_d;
    logic [NCH-1:0]    data_q, data_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              overrun_q, overrun_d;

    logic              launch;
    logic              xfer;
    logic [SEL_W-1:0]  first_ch, next_ch;
    logic              first_found, next_found;

    // First channel of a scan comes straight from the live mask, since the
    // mask is latched on the same edge the scan is launched.
    mux_next_ch u_first (
        .mask_i    (ch_mask_i),
        .cur_i     ('0),
        .from_lo_i (1'b1),
        .nxt_o     (first_ch),
        .found_o   (first_found)
    );

    // Successor of the channel currently being settled, from the latched mask.
    mux_next_ch u_next (
        .mask_i    (mask_q),
        .cur_i     (sel_q),
        .from_lo_i (1'b0),
        .nxt_o     (next_ch),
        .found_o   (next_found)
    );

    assign xfer = valid_q && scan_ready_i;

    // Next-state logic: scan walk, settle countdown, handshake and relaunch.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        cnt_d     = cnt_q;
        mask_d    = mask_q;
        data_d    = data_q;
        valid_d   = valid_q;
        busy_d    = busy_q;
        overrun_d = start_i && (state_q != IDLE);
        launch    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) launch = 1'b1;
            end
            SCAN: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    data_d[sel_q] = mux_y_i;
                    if (next_found) begin
                        sel_d = next_ch;
                        cnt_d = SETTLE_CNT;
                    end else begin
                        state_d = OUT;
                        valid_d = 1'b1;
                        busy_d  = 1'b0;
                    end
                end
            end
            OUT: begin
                if (xfer) begin
                    if (cont_i) begin
                        launch = 1'b1;
                    end else begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase

        // Common scan launch from IDLE or a continuous-mode transfer.
        // An empty mask skips straight to a zero snapshot; sel is left alone.
        if (launch) begin
            mask_d = ch_mask_i;
            data_d = '0;
            if (first_found) begin
                sel_d   = first_ch;
                cnt_d   = SETTLE_CNT;
                state_d = SCAN;
                busy_d  = 1'b1;
                valid_d = 1'b0;
            end else begin
                state_d = OUT;
                busy_d  = 1'b0;
                valid_d = 1'b1;
            end
        end
    end

    // State and output registers; reset aborts any scan with no partial output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            cnt_q     <= '0;
            mask_q    <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            cnt_q     <= cnt_d;
            mask_q    <= mask_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
        end
    end

    assign sel_o        = sel_q;
    assign scan_data_o  = data_q;
    assign scan_valid_o = valid_q;
    assign busy_o       = busy_q;
    assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl: one instance with SETTLE=2, one with SETTLE=0.
module tb_mux_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    // SETTLE=2 instance
    logic       start = 1'b0, cont = 1'b0, ready = 1'b0;
    logic [3:0] mask = 4'h0, d = 4'h0;
    logic [1:0] sel;
    logic [3:0] data;
    logic       valid, busy, ov, mux_y;

    // SETTLE=0 instance
    logic       start0 = 1'b0, cont0 = 1'b0, ready0 = 1'b0;
    logic [3:0] mask0 = 4'h0, d0 = 4'h0;
    logic [1:0] sel0;
    logic [3:0] data0;
    logic       valid0, busy0, ov0, mux_y0;

    int n_cmp = 0;
    int n_err = 0;
    int ov_cnt = 0;
    int xf_cnt = 0;
    int ov_base, xf_base;

    always #5 clk = ~clk;

    // Bench mux model: bit sel of the pattern
    assign mux_y  = d[sel];
    assign mux_y0 = d0[sel0];

    always @(posedge clk) begin
        if (ov) ov_cnt++;
        if (valid && ready) xf_cnt++;
    end

    mux_scan_ctrl #(.SETTLE(2)) u_dut (
        .clk(clk), .rst(rst), .start_i(start), .cont_i(cont), .ch_mask_i(mask),
        .sel_o(sel), .mux_y_i(mux_y), .scan_data_o(data), .scan_valid_o(valid),
        .scan_ready_i(ready), .busy_o(busy), .overrun_o(ov)
    );

    mux_scan_ctrl #(.SETTLE(0)) u_dut0 (
        .clk(clk), .rst(rst), .start_i(start0), .cont_i(cont0), .ch_mask_i(mask0),
        .sel_o(sel0), .mux_y_i(mux_y0), .scan_data_o(data0), .scan_valid_o(valid0),
        .scan_ready_i(ready0), .busy_o(busy0), .overrun_o(ov0)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset
        repeat (2) tick();
        rst = 1'b0;
        tick();
        chk("rst_sel", sel, 0);
        chk("rst_data", data, 0);
        chk("rst_valid", valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ov", ov, 0);

        // T1: mask 1111, d 1010
        mask = 4'hF; d = 4'hA; start = 1'b1;
        tick(); // edge 0
        start = 1'b0;
        for (int e = 0; e < 12; e++) begin
            chk("t1_sel", sel, e / 3);
            if (e == 0)  chk("t1_busy", busy, 1);
            if (e == 11) chk("t1_valid_early", valid, 0);
            tick();
        end
        chk("t1_valid", valid, 1);
        chk("t1_busy_out", busy, 0);
        chk("t1_data", data, 4'hA);
        chk("t1_sel_hold", sel, 3);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        chk("t1_valid_drop", valid, 0);
        tick();
        chk("t1_idle_busy", busy, 0);
        chk("t1_idle_sel", sel, 3);

        // T2: mask 0101, d 1111
        mask = 4'h5; d = 4'hF; start = 1'b1;
        tick();
        start = 1'b0;
        for (int e = 0; e < 6; e++) begin
            chk("t2_sel", sel, (e < 3) ? 0 : 2);
            if (e == 5) chk("t2_valid_early", valid, 0);
            tick();
        end
        chk("t2_valid", valid, 1);
        chk("t2_data", data, 4'h5);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        chk("t2_valid_drop", valid, 0);

        // T3: empty mask
        mask = 4'h0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("t3_valid", valid, 1);
        chk("t3_data", data, 0);
        chk("t3_busy", busy, 0);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        chk("t3_valid_drop", valid, 0);
        chk("t3_busy_after", busy, 0);

        // T4: stalls and ignored starts; mask 0011, d 0001
        ov_base = ov_cnt; xf_base = xf_cnt;
        mask = 4'h3; d = 4'h1; start = 1'b1;
        tick(); // edge 0
        start = 1'b0;
        tick(); // edge 1
        start = 1'b1;
        tick(); // edge 2
        start = 1'b0;
        chk("t4_ov_scan", ov, 1);
        tick(); // edge 3
        chk("t4_ov_clear", ov, 0);
        repeat (3) tick(); // edge 6
        chk("t4_valid", valid, 1);
        chk("t4_data", data, 4'h1);
        for (int i = 0; i < 5; i++) begin
            start = (i == 2);
            mask = 4'hF;
            tick();
            chk("t4_hold_valid", valid, 1);
            chk("t4_hold_data", data, 4'h1);
            if (i == 2) chk("t4_ov_out", ov, 1);
        end
        ready = 1'b1; start = 1'b1;
        tick(); // transfer and start on the same edge
        ready = 1'b0; start = 1'b0;
        chk("t4_xfer_valid", valid, 0);
        chk("t4_xfer_busy", busy, 0);
        chk("t4_xfer_ov", ov, 1);
        tick();
        chk("t4_idle_busy", busy, 0);
        chk("t4_idle_valid", valid, 0);
        chk("t4_idle_ov", ov, 0);
        chk("t4_ov_count", ov_cnt - ov_base, 3);
        chk("t4_xfer_count", xf_cnt - xf_base, 1);

        // T5: SETTLE=0, continuous, mask changed mid-scan
        mask0 = 4'hF; cont0 = 1'b1; ready0 = 1'b1; d0 = 4'h6; start0 = 1'b1;
        tick(); // edge 0
        start0 = 1'b0;
        chk("t5_sel0", sel0, 0);
        chk("t5_busy", busy0, 1);
        tick(); // edge 1
        mask0 = 4'h3;
        chk("t5_sel1", sel0, 1);
        repeat (3) tick(); // edge 4
        chk("t5_valid1", valid0, 1);
        chk("t5_data1", data0, 4'h6);
        tick(); // edge 5: transfer, relaunch with 0011
        cont0 = 1'b0;
        chk("t5_relaunch_valid", valid0, 0);
        chk("t5_relaunch_busy", busy0, 1);
        chk("t5_relaunch_sel", sel0, 0);
        tick(); // edge 6
        chk("t5_sel2", sel0, 1);
        chk("t5_valid_early", valid0, 0);
        tick(); // edge 7
        chk("t5_valid2", valid0, 1);
        chk("t5_data2", data0, 4'h2);
        tick(); // edge 8: transfer, cont low
        chk("t5_end_valid", valid0, 0);
        chk("t5_end_busy", busy0, 0);
        tick();
        chk("t5_idle_valid", valid0, 0);
        chk("t5_idle_busy", busy0, 0);
        ready0 = 1'b0;

        // T6: async reset mid-scan, then a clean scan
        mask = 4'hF; d = 4'hA; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        chk("t6_sel_pre", sel, 2);
        chk("t6_busy_pre", busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_sel", sel, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_valid", valid, 0);
        chk("t6_rst_data", data, 0);
        chk("t6_rst_ov", ov, 0);
        tick();
        rst = 1'b0;
        tick();
        mask = 4'h6; d = 4'hF; start = 1'b1;
        tick();
        start = 1'b0;
        chk("t6_sel_first", sel, 1);
        repeat (5) tick();
        chk("t6_valid_early", valid, 0);
        tick();
        chk("t6_valid", valid, 1);
        chk("t6_data", data, 4'h6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mux_scan_ctrl.md
# mux_scan_ctrl

Upstream sequencer for the 4:1 bit multiplexer. It drives the mux select lines and scans the enabled input channels in order. After a programmable settle time it samples the muxed bit of each channel and assembles the samples into a 4-bit snapshot word. The snapshot goes downstream over a valid/ready handshake, as a single scan or as continuous back-to-back scans.

## Interface
Parameters:
- SETTLE, default 2: extra cycles `sel` is held stable before sampling; legal range 0..15.

Ports:
- clk  in  1  the single clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request one scan; acted on only in IDLE.
- cont  in  1  continuous mode; sampled at each transfer edge.
- ch_mask  in  4  channel enables, bit i = channel i; latched when a scan starts.
- sel  out  2  select to the 4:1 mux.
- mux_y  in  1  muxed data bit returned from the 4:1 mux.
- scan_data  out  4  snapshot; bit i = sample of channel i, 0 if channel i is disabled.
- scan_valid  out  1  snapshot available.
- scan_ready  in  1  downstream accepts the snapshot.
- busy  out  1  a scan is in progress (SCAN state).
- overrun  out  1  one-cycle pulse: `start` was ignored.

## Operation
States:
- IDLE:
  - `start`=1 latches `ch_mask` and clears the data register.
  - If the mask is nonzero: load `sel` with the lowest enabled channel, load the settle counter with SETTLE, go to SCAN.
  - If the mask is 0: go directly to OUT with `scan_data`=0.
- SCAN:
  - The counter decrements each cycle while nonzero.
  - On the edge where the counter is 0: write `mux_y` into data bit `sel`.
  - If a higher enabled channel exists: `sel` takes that channel and the counter reloads with SETTLE.
  - Otherwise go to OUT.
- OUT:
  - `scan_valid`=1; `scan_data` and `sel` are held.
  - Transfer happens on a `scan_valid`&&`scan_ready` edge.
  - On transfer with `cont`=1: relatch `ch_mask` and start a new scan, entering SCAN or OUT by the same rules as IDLE.
  - On transfer with `cont`=0: go to IDLE.

Rules:
- Disabled channels are skipped, never selected, and read as 0.
- `ch_mask` changes during SCAN or OUT have no effect on the current scan.
- `start`=1 in SCAN or OUT is ignored and pulses `overrun` for exactly one cycle.
- `start` and a transfer on the same edge: the transfer occurs and `start` is ignored with an `overrun` pulse.
- `cont` deasserted mid-scan: the current scan completes and is delivered, then the block goes to IDLE.
- Reset values: state IDLE, `sel`=0, `scan_data`=0, `scan_valid`=0, `busy`=0, `overrun`=0, counter=0, latched mask=0.
- Reset asserted mid-scan or in OUT aborts immediately with no partial output.
- `sel` stays at its last value in IDLE.

## Timing
- Timing is counted from edge 0, the edge at which `start` is sampled in IDLE.
- With N enabled channels, `sel` takes the first channel after edge 0.
- The k-th enabled channel (k = 1..N) is sampled at edge k·(SETTLE+1); `sel` advances at that same edge.
- `scan_valid` rises after edge N·(SETTLE+1). For N=0 it rises after edge 0.
- Each channel's `sel` value is stable for SETTLE+1 full cycles before its sampling edge.
- The mux is combinational, so `mux_y` must be valid within those cycles.
- `scan_valid` drops the cycle after transfer.
- In continuous mode the next scan's first sample lands SETTLE+1 edges after the transfer edge, so there is no idle bubble beyond that.
- `busy` and `scan_valid` are never both 1.
- All outputs are registered.

## Structure
- Package `mux_scan_pkg` holds:
  - NCH=4, SEL_W=2, CNT_W=4.
  - State enum {IDLE, SCAN, OUT}.
- Sub-module `mux_next_ch`: combinational; inputs are the mask and the current channel; outputs are the next enabled channel strictly above the current one and a found flag.
  - It is reused, with the current channel treated as −1, to find the first channel.
- The top holds the FSM, settle counter, data register, and handshake.

## Test plan
- SETTLE=2, `ch_mask`=1111, bench mux model d=1010 driven by `sel`, single `start` -> `sel` sequence 0,1,2,3 with each value held 3 cycles; `scan_data`=1010; `scan_valid` after edge 12; back to IDLE after transfer.
- SETTLE=2, `ch_mask`=0101, d=1111 -> `sel` 0 then 2; `scan_data`=0101; `scan_valid` after edge 6.
- `ch_mask`=0000, `start` -> `scan_valid` after edge 0 with `scan_data`=0000; `busy` never asserts.
- Single scan, `scan_ready` low for 5 cycles in OUT, `start` pulsed in SCAN and in OUT -> data and valid held stable; `overrun` pulses once per ignored `start`; exactly one transfer.
- SETTLE=0, `cont`=1, `ch_mask`=1111 with `ch_mask` changed to 0011 mid-scan, `scan_ready`=1 -> first snapshot uses 1111; next scan uses 0011 and its valid rises 2 edges after the transfer; clearing `cont` ends after the current delivery.
- `rst` asserted during SCAN with `sel`=2 -> all outputs immediately return to reset values; a following `start` completes a clean scan.
